// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter.
// State encoding and the byte type used on client and UART sides.
package uart_arb_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_ACCEPT,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping.
// Purely combinational; N need not be a power of two.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked sharing of one uart_tx among N_REQ clients.
// Owner keeps the UART until last byte, req drop, or MAX_BURST bytes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int MAX_BURST = 16,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      last,
  input  byte_t [N_REQ-1:0]     data,
  output logic [N_REQ-1:0]      ack,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  uart_send,
  output byte_t                 uart_data,
  input  logic                  uart_busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic             last_q;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             own_req;
  logic [IDX_W-1:0] ptr_next;

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_req  = req[grant_idx];
  assign ptr_next = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;

  // A byte is only handed over while its owner still requests.
  assign uart_send = (state == LOAD) && !uart_busy && own_req;
  assign ack       = uart_send ? (N_REQ'(1) << grant_idx) : '0;
  assign uart_data = grant_valid ? data[grant_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
      count       <= '0;
      last_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            count       <= '0;
            last_q      <= 1'b0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (!own_req) begin
            ptr         <= ptr_next;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else if (!uart_busy) begin
            last_q <= last[grant_idx];
            count  <= count + 1'b1;
            state  <= WAIT_ACCEPT;
          end
        end
        WAIT_ACCEPT: begin
          if (uart_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!uart_busy) begin
            if (last_q || count == CNT_MAX || !own_req) begin
              ptr         <= ptr_next;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
